// File: rtl/sorter_feeder.sv
// sorter_feeder: buffers one QPSK/QAM16 metric frame and replays it to the sorter as start + groups of four.
// Define SORTER_FEEDER_DONE_WAIT_EN to hold each frame until the sorter reports done.
module sorter_feeder #(
   parameter int WIDTH       = 8,
   parameter int MAX_METRICS = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [1:0]       i_m,
   input  logic             i_in_valid,
   input  logic [WIDTH-1:0] i_in_data,
   output logic             o_in_ready,
   output logic             o_start,
   output logic [WIDTH-1:0] o_d1,
   output logic [WIDTH-1:0] o_d2,
   output logic [WIDTH-1:0] o_d3,
   output logic [WIDTH-1:0] o_d4,
   output logic [1:0]       o_m_out,
   input  logic             i_sorter_done,
   output logic             o_busy,
   output logic             o_mode_err
);
   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_START, S_GAP, S_ISSUE
`ifdef SORTER_FEEDER_DONE_WAIT_EN
      , S_WAIT_DONE
`endif
   } state_t;

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_buf [MAX_METRICS];
   logic [3:0]       r_widx;
   logic [1:0]       r_grp;
   logic [1:0]       r_m_out;
   logic [WIDTH-1:0] r_d1, r_d2, r_d3, r_d4;
   logic             r_start, r_busy, r_mode_err;
   logic             w_accept, w_widx_last, w_grp_last;
   logic [1:0]       w_gsel;

`ifndef SORTER_FEEDER_DONE_WAIT_EN
   logic w_unused;
   assign w_unused = i_sorter_done;
`endif

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_FILL;
         S_FILL:  if (w_accept && w_widx_last) w_next = S_START;
         S_START: w_next = S_GAP;
         S_GAP:   w_next = S_ISSUE;
`ifdef SORTER_FEEDER_DONE_WAIT_EN
         S_ISSUE:     if (w_grp_last) w_next = S_WAIT_DONE;
         S_WAIT_DONE: if (i_sorter_done) w_next = S_IDLE;
`else
         S_ISSUE: if (w_grp_last) w_next = S_IDLE;
`endif
         default: w_next = S_IDLE;
      endcase
   end

   // r_m_out only ever holds 00 or 01, so bit 0 selects the frame length
   always_comb begin
      o_in_ready  = !i_rst && (r_state == S_IDLE || r_state == S_FILL);
      w_accept    = i_in_valid && o_in_ready;
      w_widx_last = r_state == S_FILL && r_widx == (r_m_out[0] ? 4'd15 : 4'd3);
      w_grp_last  = r_grp == (r_m_out[0] ? 2'd3 : 2'd0);
      w_gsel      = (r_state == S_ISSUE) ? r_grp + 2'd1 : 2'd0;
   end

   always_ff @(posedge i_clk)
      if (w_accept) r_buf[r_widx] <= i_in_data;

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_widx     <= '0;
         r_grp      <= '0;
         r_m_out    <= '0;
         r_start    <= 1'b0;
         r_busy     <= 1'b0;
         r_mode_err <= 1'b0;
         r_d1       <= '0;
         r_d2       <= '0;
         r_d3       <= '0;
         r_d4       <= '0;
      end else begin
         r_widx     <= w_accept ? (w_widx_last ? 4'd0 : r_widx + 4'd1) : r_widx;
         r_grp      <= (r_state == S_ISSUE && !w_grp_last) ? r_grp + 2'd1 : 2'd0;
         r_m_out    <= (r_state == S_IDLE && w_accept) ? (i_m[1] ? 2'b00 : i_m) : r_m_out;
         r_mode_err <= r_state == S_IDLE && w_accept && i_m[1];
         r_start    <= w_next == S_START;
         r_busy     <= w_next != S_IDLE;
         r_d1       <= (w_next == S_ISSUE) ? r_buf[{w_gsel, 2'd0}] : '0;
         r_d2       <= (w_next == S_ISSUE) ? r_buf[{w_gsel, 2'd1}] : '0;
         r_d3       <= (w_next == S_ISSUE) ? r_buf[{w_gsel, 2'd2}] : '0;
         r_d4       <= (w_next == S_ISSUE) ? r_buf[{w_gsel, 2'd3}] : '0;
      end

   assign o_start    = r_start;
   assign o_busy     = r_busy;
   assign o_mode_err = r_mode_err;
   assign o_m_out    = r_m_out;
   assign o_d1       = r_d1;
   assign o_d2       = r_d2;
   assign o_d3       = r_d3;
   assign o_d4       = r_d4;
endmodule

// File: tb/tb_sorter_feeder.sv
// tb_sorter_feeder: directed checks of sorter_feeder framing, latency, mode handling and reset.
module tb_sorter_feeder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] m = 2'b00;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       sorter_done = 1'b0;
   logic       in_ready, start, busy, mode_err;
   logic [7:0] d1, d2, d3, d4;
   logic [1:0] m_out;
   int         total = 0;
   int         bad = 0;
   logic [7:0] q [16] = '{8'd10, 8'd20, 8'd1, 8'd0, 8'd40, 8'd3, 8'd8, 8'd22,
                          8'd100, 8'd4, 8'd120, 8'd6, 8'd122, 8'd86, 8'd91, 8'd15};

   sorter_feeder #(.WIDTH(8), .MAX_METRICS(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_m(m), .i_in_valid(in_valid), .i_in_data(in_data),
      .o_in_ready(in_ready), .o_start(start), .o_d1(d1), .o_d2(d2), .o_d3(d3), .o_d4(d4),
      .o_m_out(m_out), .i_sorter_done(sorter_done), .o_busy(busy), .o_mode_err(mode_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] v);
      in_valid = 1'b1;
      in_data  = v;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic grp(input string tag, input logic [7:0] a, b, c, d);
      chk({tag, ".d1"}, d1, a);
      chk({tag, ".d2"}, d2, b);
      chk({tag, ".d3"}, d3, c);
      chk({tag, ".d4"}, d4, d);
   endtask

   // called in the last issue cycle; returns in the first IDLE cycle
   task automatic finish_frame(input string tag);
      tick();
`ifdef SORTER_FEEDER_DONE_WAIT_EN
      chk({tag, ".wait_busy"}, busy, 1);
      chk({tag, ".wait_ready"}, in_ready, 0);
      sorter_done = 1'b1;
      tick();
      sorter_done = 1'b0;
`endif
      chk({tag, ".idle_ready"}, in_ready, 1);
      chk({tag, ".idle_busy"}, busy, 0);
      chk({tag, ".idle_d1"}, d1, 0);
   endtask

   initial begin
      tick();
      tick();
      chk("rst.in_ready", in_ready, 0);
      chk("rst.start", start, 0);
      chk("rst.busy", busy, 0);
      chk("rst.m_out", m_out, 0);
      chk("rst.mode_err", mode_err, 0);
      grp("rst", 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      chk("rel.in_ready", in_ready, 1);

      m = 2'b00;
      send(10); send(20); send(1); send(0);
      chk("qpsk.start", start, 1);
      chk("qpsk.busy", busy, 1);
      chk("qpsk.ready", in_ready, 0);
      tick();
      chk("qpsk.start_off", start, 0);
      grp("qpsk.gap", 0, 0, 0, 0);
      tick();
      grp("qpsk.g0", 10, 20, 1, 0);
      finish_frame("qpsk");

      m = 2'b01;
      for (int i = 0; i < 16; i++) send(q[i]);
      chk("qam.start", start, 1);
      chk("qam.m_out", m_out, 1);
      tick();
      grp("qam.gap", 0, 0, 0, 0);
      for (int g = 0; g < 4; g++) begin
         tick();
         grp($sformatf("qam.g%0d", g), q[4*g], q[4*g+1], q[4*g+2], q[4*g+3]);
      end
      finish_frame("qam");

      for (int i = 0; i < 16; i++) begin
         if (i > 0) tick();
         send(q[i]);
      end
      in_valid = 1'b1;
      in_data  = 8'hEE;
      chk("bp.start", start, 1);
      chk("bp.ready_start", in_ready, 0);
      tick();
      chk("bp.ready_gap", in_ready, 0);
      for (int g = 0; g < 4; g++) begin
         tick();
         chk("bp.ready_issue", in_ready, 0);
         grp($sformatf("bp.g%0d", g), q[4*g], q[4*g+1], q[4*g+2], q[4*g+3]);
      end
      in_valid = 1'b0;
      finish_frame("bp");

      m = 2'b11;
      send(5);
      chk("mode.err", mode_err, 1);
      chk("mode.m_out", m_out, 0);
      m = 2'b01;
      send(6);
      chk("mode.err_off", mode_err, 0);
      send(7); send(8);
      chk("mode.start", start, 1);
      tick();
      tick();
      grp("mode.g0", 5, 6, 7, 8);
      finish_frame("mode");

      m = 2'b01;
      for (int i = 0; i < 16; i++) send(q[i]);
      tick(); tick(); tick();
      grp("rsti.g1", 40, 3, 8, 22);
      rst = 1'b1;
      #1;
      grp("rsti.async", 0, 0, 0, 0);
      chk("rsti.busy", busy, 0);
      chk("rsti.ready", in_ready, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rsti.no_start", start, 0);
         chk("rsti.no_busy", busy, 0);
      end
      m = 2'b00;
      send(1); send(2); send(3); send(4);
      chk("post.start", start, 1);
      chk("post.m_out", m_out, 0);
      tick();
      tick();
      grp("post.g0", 1, 2, 3, 4);
      finish_frame("post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sorter_feeder.md
# sorter_feeder

Upstream companion of the `sorter` stage. Collects metric values one per cycle over a valid/ready stream and buffers one frame:
- 4 metrics for QPSK.
- 16 metrics for QAM16.

It then drives the sorter's `start`/`d1..d4` load protocol, one `start` pulse followed by groups of four metrics on consecutive cycles. Optionally, it holds off the next frame until the sorter reports `done`.

## Interface
- `WIDTH`, 8, bit width of one metric and of each of `d1..d4`.
- `MAX_METRICS`, 16, buffer depth in metrics; fixed at 16 (QAM16 frame size).
- `clk`  input  1  single clock; all logic on rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `M`  input  2  modulation: 2'b00 QPSK (4 metrics), 2'b01 QAM16 (16 metrics), 2'b1x reserved.
- `in_valid`  input  1  `in_data` valid this cycle.
- `in_data`  input  WIDTH  metric value.
- `in_ready`  output  1  feeder accepts a metric this cycle.
- `start`  output  1  one-cycle frame start pulse to the sorter.
- `d1`, `d2`, `d3`, `d4`  output  WIDTH each  metric group to the sorter.
- `M_out`  output  2  latched modulation of the frame being issued; drives the sorter's `M`.
- `sorter_done`  input  1  sorter `done` indication.
- `busy`  output  1  high in every state except IDLE.
- `mode_err`  output  1  one-cycle pulse when a frame is begun with reserved `M`.

## Operation
- Accept: a transfer occurs on a cycle with `in_valid && in_ready`.
- States: IDLE, FILL, START, GAP, ISSUE, WAIT_DONE.
- IDLE:
  - `in_ready`=1.
  - On the first accept, latch `M` into `M_out`.
    - If `M` is reserved, pulse `mode_err` and latch 2'b00 (the frame is treated as QPSK).
  - Store the metric at index 0 and go to FILL. If the frame length is 1, which cannot occur, no special case is needed.
- FILL:
  - `in_ready`=1.
  - Store each accepted metric at the next index, 0..N-1, with N = 4 for QPSK and 16 for QAM16.
  - The accept that writes index N-1 moves to START.
  - `M` changes during FILL are ignored.
- START: `in_ready`=0, `start`=1 for exactly this cycle; go to GAP.
- GAP: one idle cycle, `d1..d4`=0; go to ISSUE.
- ISSUE:
  - For group g = 0..N/4-1, one group per cycle: `d1`=buf[4g], `d2`=buf[4g+1], `d3`=buf[4g+2], `d4`=buf[4g+3].
  - After the last group, go to WAIT_DONE, or per the Configuration section.
- WAIT_DONE: `in_ready`=0. On `sorter_done`=1, return to IDLE.
- `d1..d4` are 0 in every state except ISSUE.
- `sorter_done` outside WAIT_DONE is ignored.
- Buffer contents are not cleared between frames; only written indices are issued.
- Arithmetic:
  - Write index: 4 bits, wraps never, because the terminal index ends FILL.
  - Group counter: 2 bits.

## Timing
- Reset values:
  - `in_ready`=0 while `rst`=1, then 1 from the first cycle after release.
  - `start`=0, `d1..d4`=0, `M_out`=2'b00, `busy`=0, `mode_err`=0.
  - State is IDLE and counters are 0.
- All outputs are registered except `in_ready`, which is a decode of the state register.
- Latency, with the last metric accepted at edge t:
  - `start` is high in cycle t+1.
  - Group 0 is on `d1..d4` in cycle t+3.
  - The last group is in cycle t+2+N/4.
- QPSK: 1 issue cycle. QAM16: 4 consecutive issue cycles, no bubbles.
- The earliest next accept is the cycle after `sorter_done` is sampled high.
- `in_valid` gaps during FILL stall the fill without losing data. Accepted data is never dropped.
- `rst` asserted in any state:
  - Immediately clears all outputs and returns to IDLE.
  - A partial frame is discarded.
  - No `start` or `d` activity follows until a new full frame is collected.

## Configuration
- Macro: `SORTER_FEEDER_DONE_WAIT_EN`.
- Defined: behaviour as above. After ISSUE, the block sits in WAIT_DONE until `sorter_done`.
- Undefined:
  - The WAIT_DONE state is not built and `sorter_done` is unused.
  - After the last ISSUE cycle, the state returns to IDLE and `in_ready`=1 on the next cycle.
  - `busy` falls at the same time.

## Test plan
- QPSK: `M`=00, accept 10,20,1,0 → `start` pulse at t+1; cycle t+3 `d1`=10 `d2`=20 `d3`=1 `d4`=0; `busy` stays high until `sorter_done`.
- QAM16: `M`=01, accept 10,20,1,0,40,3,8,22,100,4,120,6,122,86,91,15 → `start` at t+1; groups {10,20,1,0}, {40,3,8,22}, {100,4,120,6}, {122,86,91,15} on cycles t+3..t+6; `M_out`=01.
- Backpressure/gaps: QAM16 with `in_valid` low on every other cycle → identical `d` sequence; `in_ready`=0 from START until `sorter_done`; an `in_valid` held during that window is not consumed.
- Mode handling: `M`=11 at the first accept → `mode_err` one pulse and a 4-metric frame with `M_out`=00; `M` toggled to 01 mid-FILL → frame length stays 4.
- Reset mid-ISSUE: assert `rst` on QAM16 group 1 → `d1..d4`=0 and `busy`=0 asynchronously; no further `start`; a fresh QPSK frame then completes normally.
- Macro undefined: `sorter_done` tied 0 → after QPSK issue, `in_ready`=1 on the next cycle and a second frame is accepted.
